// File: rtl/rename_seg_ctl_pkg.sv
// Shared types and helpers for the rename segment-header controller.
// A map is NUM_LREG entries of {vld, tag}; vld sits at the MSB of each entry.
package rename_pkg;

  // Upper bound on map width so the identity-map builder can return a fixed-size vector.
  localparam int MAX_MAP_W = 4096;

  function automatic int map_w(input int nlreg, input int pbits);
    return nlreg * (pbits + 1);
  endfunction

  function automatic int seg_bits(input int nseg);
    return (nseg < 2) ? 1 : $clog2(nseg);
  endfunction

  function automatic int cnt_bits(input int isq, input int port);
    return ((isq / port) < 2) ? 1 : $clog2(isq / port);
  endfunction

  // Identity map: entry i = {1'b1, i}; callers slice the low map_w() bits.
  function automatic logic [MAX_MAP_W-1:0] id_map(input int nlreg, input int pbits);
    logic [MAX_MAP_W-1:0] m;
    m = '0;
    for (int i = 0; i < nlreg; i++) begin
      for (int b = 0; b < pbits; b++) m[i*(pbits+1)+b] = i[b];
      m[i*(pbits+1)+pbits] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rename_seg_ctl_if.sv
// Bus between the rename array / issue queue and the segment-header controller.
// master drives line status and payload; slave (the controller) returns headers and rotated data.
interface rename_seg_ctl_if import rename_pkg::*; #(
  parameter int ISQ_DEPTH = 64,
  parameter int NUM_SEG   = 4,
  parameter int NUM_LREG  = 16,
  parameter int PREG_BITS = 6,
  parameter int INST_PORT = 4,
  parameter int ROT_W     = 62
) ();
  localparam int MAP_W    = map_w(NUM_LREG, PREG_BITS);
  localparam int CNT_BITS = cnt_bits(ISQ_DEPTH, INST_PORT);
  localparam int SEG_BITS = seg_bits(NUM_SEG);

  logic [NUM_SEG*MAP_W-1:0]   seg_tail_map_flat;
  logic [ISQ_DEPTH-1:0]       inst_vld;
  logic [ISQ_DEPTH-1:0]       inst_wat;
  logic [ISQ_DEPTH-1:0]       inst_brn_wat;
  logic [CNT_BITS-1:0]        counter;
  logic                       rcv;
  logic [ISQ_DEPTH*ROT_W-1:0] rot_in_flat;
  logic [ISQ_DEPTH-1:0]       rdy_raw;
  logic [NUM_SEG*MAP_W-1:0]   seg_hed_map_flat;
  logic [SEG_BITS-1:0]        arch_seg;
  logic                       arch_swt;
  logic [ISQ_DEPTH-1:0]       arch_swt_fls;
  logic                       isq_ful;
  logic [ISQ_DEPTH*ROT_W-1:0] rot_out_flat;
  logic [ISQ_DEPTH-1:0]       rdy_out;

  modport master (
    output seg_tail_map_flat, inst_vld, inst_wat, inst_brn_wat, counter, rcv, rot_in_flat, rdy_raw,
    input  seg_hed_map_flat, arch_seg, arch_swt, arch_swt_fls, isq_ful, rot_out_flat, rdy_out
  );

  modport slave (
    input  seg_tail_map_flat, inst_vld, inst_wat, inst_brn_wat, counter, rcv, rot_in_flat, rdy_raw,
    output seg_hed_map_flat, arch_seg, arch_swt, arch_swt_fls, isq_ful, rot_out_flat, rdy_out
  );
endinterface

// File: rtl/rename_seg_ctl_seg_rot.sv
// Segment-granular rotator: output line j = input line (j + sel*SEG_DEPTH) mod DEPTH,
// so the head segment lands at line 0. Pure combinational mux over NSEG rotations.
module seg_rot #(
  parameter int W     = 1,
  parameter int DEPTH = 64,
  parameter int NSEG  = 4,
  parameter int SBITS = 2
) (
  input  logic [SBITS-1:0]   sel_i,
  input  logic [DEPTH*W-1:0] din_i,
  output logic [DEPTH*W-1:0] dout_o
);
  localparam int SD = DEPTH / NSEG;

  logic [DEPTH-1:0][W-1:0]            din;
  logic [NSEG-1:0][DEPTH-1:0][W-1:0]  rot;
  logic [DEPTH-1:0][W-1:0]            dout;

  assign din = din_i;

  for (genvar r = 0; r < NSEG; r++) begin : g_rot
    for (genvar j = 0; j < DEPTH; j++) begin : g_line
      assign rot[r][j] = din[(j + r*SD) % DEPTH];
    end
  end

  assign dout   = rot[sel_i];
  assign dout_o = dout;
endmodule

// File: rtl/rename_seg_ctl.sv
// Segment-header controller for the rename translation array.
// Keeps the architectural map and the head segment H; commits H's tail map once
// every line of H has retired, rotates per-line payload so H sits at line 0.
module rename_seg_ctl import rename_pkg::*; #(
  parameter int ISQ_DEPTH = 64,
  parameter int NUM_SEG   = 4,
  parameter int NUM_LREG  = 16,
  parameter int PREG_BITS = 6,
  parameter int INST_PORT = 4,
  parameter int ROT_W     = 62
) (
  input logic            clk,
  input logic            rst_n,
  rename_seg_ctl_if.slave bus
);
  localparam int SEG_DEPTH = ISQ_DEPTH / NUM_SEG;
  localparam int GPS       = SEG_DEPTH / INST_PORT;
  localparam int NGRP      = ISQ_DEPTH / INST_PORT;
  localparam int ENT_W     = PREG_BITS + 1;
  localparam int MAP_W     = map_w(NUM_LREG, PREG_BITS);
  localparam int CNT_BITS  = cnt_bits(ISQ_DEPTH, INST_PORT);
  localparam int SEG_BITS  = seg_bits(NUM_SEG);
  localparam logic [MAX_MAP_W-1:0] ID_FULL = id_map(NUM_LREG, PREG_BITS);
  localparam logic [MAP_W-1:0]     ID_MAP  = ID_FULL[MAP_W-1:0];

  logic [MAP_W-1:0]                   arch_map_q, arch_map_d;
  logic [SEG_BITS-1:0]                h_q, h_d;
  logic [NUM_SEG-1:0][MAP_W-1:0]      tail, hed;
  logic [MAP_W-1:0]                   tail_h;
  logic [ISQ_DEPTH-1:0]               done;
  logic [NUM_SEG-1:0][SEG_DEPTH-1:0]  done_seg, fls_seg;
  logic                               seg_done, tail_res, swt;
  logic [CNT_BITS-1:0]                cseg, ful_grp;

  assign tail   = bus.seg_tail_map_flat;
  assign tail_h = tail[h_q];

  // A line is retired when empty or no longer waiting on issue or branch.
  assign done     = ~bus.inst_vld | (~bus.inst_wat & ~bus.inst_brn_wat);
  assign done_seg = done;
  assign seg_done = &done_seg[h_q];

  // Head tail map is only committable once every logical entry carries a valid tag.
  always_comb begin
    tail_res = 1'b1;
    for (int i = 0; i < NUM_LREG; i++) tail_res = tail_res & tail_h[i*ENT_W + PREG_BITS];
  end

  // Dispatch segment; committing while dispatch still targets H would race the flush.
  assign cseg = bus.counter / CNT_BITS'(GPS);
  assign swt  = rst_n & ~bus.rcv & seg_done & tail_res & (cseg != CNT_BITS'(h_q));

  // Queue is full when dispatch reaches the last group of the segment behind H.
  always_comb begin
    if (h_q == '0) ful_grp = CNT_BITS'(NGRP - 1);
    else           ful_grp = CNT_BITS'(h_q) * CNT_BITS'(GPS) - CNT_BITS'(1);
  end

  for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
    // Head segment chains from the architectural map, others from the previous segment's tail.
    assign hed[s]     = (h_q == SEG_BITS'(s)) ? arch_map_q : tail[(s + NUM_SEG - 1) % NUM_SEG];
    assign fls_seg[s] = {SEG_DEPTH{bus.rcv | (swt & (h_q == SEG_BITS'(s)))}};
  end

  assign bus.seg_hed_map_flat = hed;
  assign bus.arch_swt_fls     = fls_seg;
  assign bus.arch_swt         = swt;
  assign bus.arch_seg         = h_q;
  assign bus.isq_ful          = (bus.counter == ful_grp);

  // Commit: adopt the head's tail map and advance H (wraps on power-of-two NUM_SEG).
  always_comb begin
    arch_map_d = arch_map_q;
    h_d        = h_q;
    if (swt) begin
      arch_map_d = tail_h;
      h_d        = h_q + SEG_BITS'(1);
    end
  end

  // Architectural state; async reset drops any pending commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arch_map_q <= ID_MAP;
      h_q        <= '0;
    end else begin
      arch_map_q <= arch_map_d;
      h_q        <= h_d;
    end
  end

  seg_rot #(.W(ROT_W), .DEPTH(ISQ_DEPTH), .NSEG(NUM_SEG), .SBITS(SEG_BITS)) u_rot_pay (
    .sel_i (h_q),
    .din_i (bus.rot_in_flat),
    .dout_o(bus.rot_out_flat)
  );

  seg_rot #(.W(1), .DEPTH(ISQ_DEPTH), .NSEG(NUM_SEG), .SBITS(SEG_BITS)) u_rot_rdy (
    .sel_i (h_q),
    .din_i (bus.rdy_raw),
    .dout_o(bus.rdy_out)
  );
endmodule

// File: tb/tb_rename_seg_ctl.sv
// Bench for rename_seg_ctl: hand table at H=0, directed multi-cycle sequences,
// then randomized traffic against a behavioural model of head pointer and arch map.
module tb_rename_seg_ctl;
  localparam int D = 64, NS = 4, NL = 16, PB = 6, EW = 7, MW = 112, RW = 62, SD = 16;

  logic clk, rst_n;
  int   pass_cnt = 0, tot_cnt = 0;
  int   m_h;
  logic [MW-1:0] m_map;

  rename_seg_ctl_if #(.ISQ_DEPTH(D), .NUM_SEG(NS), .NUM_LREG(NL), .PREG_BITS(PB),
                      .INST_PORT(4), .ROT_W(RW)) bus ();

  rename_seg_ctl #(.ISQ_DEPTH(D), .NUM_SEG(NS), .NUM_LREG(NL), .PREG_BITS(PB),
                   .INST_PORT(4), .ROT_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] vld, wat, brn;
    logic [3:0]  cnt;
    logic        rcv, bad;
    logic        swt;
    logic [63:0] fls;
    logic        ful;
  } vec_t;

  vec_t tv[13];

  // Map with tags base..base+15 (mod 64); entry 'bad' has its valid bit cleared.
  function automatic logic [MW-1:0] mk_map(input int base, input int bad);
    logic [MW-1:0] m;
    for (int i = 0; i < NL; i++) begin
      logic [5:0] t;
      t = 6'((base + i) % 64);
      m[i*EW +: EW] = {(i != bad), t};
    end
    return m;
  endfunction

  task automatic set_tail(input int s, input logic [MW-1:0] v);
    bus.seg_tail_map_flat[s*MW +: MW] = v;
  endtask

  task automatic m_reset();
    m_h   = 0;
    m_map = mk_map(0, -1);
  endtask

  function automatic logic exp_swt_f();
    if (!rst_n || bus.rcv) return 1'b0;
    for (int i = m_h*SD; i < m_h*SD + SD; i++)
      if (bus.inst_vld[i] && (bus.inst_wat[i] || bus.inst_brn_wat[i])) return 1'b0;
    for (int l = 0; l < NL; l++)
      if (!bus.seg_tail_map_flat[m_h*MW + l*EW + PB]) return 1'b0;
    if (int'(bus.counter) / 4 == m_h) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic chk_map(input string nm, input logic [NS*MW-1:0] act, input logic [NS*MW-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic chk_rot(input string nm, input logic [D*RW-1:0] act, input logic [D*RW-1:0] exp);
    int j;
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      j = 0;
      while (j < D - 1 && act[j*RW +: RW] === exp[j*RW +: RW]) j++;
      $display("FAIL %s line %0d: got %h, want %h", nm, j, act[j*RW +: RW], exp[j*RW +: RW]);
    end
  endtask

  // Compare every output against values derived from the model and current inputs.
  task automatic check_all(input string tag);
    logic              e_swt, e_ful;
    logic [63:0]       e_fls;
    logic [NS*MW-1:0]  e_hed;
    logic [D-1:0]      e_rdy;
    logic [D*RW-1:0]   e_rot;
    int                src;
    e_swt = exp_swt_f();
    e_fls = bus.rcv ? '1 : (e_swt ? (64'hFFFF << (SD*m_h)) : 64'h0);
    e_ful = (int'(bus.counter) == (m_h*4 + 15) % 16);
    for (int s = 0; s < NS; s++)
      e_hed[s*MW +: MW] = (s == m_h) ? m_map : bus.seg_tail_map_flat[((s+NS-1)%NS)*MW +: MW];
    for (int j = 0; j < D; j++) begin
      src = (j + m_h*SD) % D;
      e_rdy[j] = bus.rdy_raw[src];
      e_rot[j*RW +: RW] = bus.rot_in_flat[src*RW +: RW];
    end
    chk({tag, ".seg"}, 64'(bus.arch_seg), 64'(m_h));
    chk({tag, ".swt"}, 64'(bus.arch_swt), 64'(e_swt));
    chk({tag, ".fls"}, bus.arch_swt_fls, e_fls);
    chk({tag, ".ful"}, 64'(bus.isq_ful), 64'(e_ful));
    chk({tag, ".rdy"}, bus.rdy_out, e_rdy);
    chk_map({tag, ".hed"}, bus.seg_hed_map_flat, e_hed);
    chk_rot({tag, ".rot"}, bus.rot_out_flat, e_rot);
  endtask

  // Advance one clock; the model commits on the edge when its rules say so.
  task automatic step();
    logic s;
    s = exp_swt_f();
    @(posedge clk);
    if (rst_n && s) begin
      m_map = bus.seg_tail_map_flat[m_h*MW +: MW];
      m_h   = (m_h + 1) % NS;
    end
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    m_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic std_tails();
    for (int s = 0; s < NS; s++) set_tail(s, mk_map(16*(s+1), -1));
  endtask

  task automatic rand_payload();
    for (int w = 0; w < D*RW/32; w++) bus.rot_in_flat[w*32 +: 32] = $urandom;
    bus.rdy_raw = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b1;
    bus.inst_vld = '0; bus.inst_wat = '0; bus.inst_brn_wat = '0;
    bus.counter = 4'd5; bus.rcv = 1'b0;
    std_tails();
    rand_payload();
    m_reset();
    #1 rst_n = 1'b0;

    // Reset held with commit conditions otherwise met: no switch while in reset.
    @(negedge clk); #1;
    check_all("rst");
    chk("rst.id", 64'(bus.arch_swt), 64'h0);
    chk_map("rst.hed0", {{(NS-1)*MW{1'b0}}, bus.seg_hed_map_flat[MW-1:0]}, {{(NS-1)*MW{1'b0}}, mk_map(0, -1)});
    @(negedge clk);
    rst_n = 1'b1;

    tv[0]  = '{64'h0,     64'h0,     64'h0, 4'd5,  1'b0, 1'b0, 1'b1, 64'hFFFF, 1'b0};
    tv[1]  = '{64'h8,     64'h8,     64'h0, 4'd5,  1'b0, 1'b0, 1'b0, 64'h0,    1'b0};
    tv[2]  = '{64'h8,     64'h0,     64'h8, 4'd5,  1'b0, 1'b0, 1'b0, 64'h0,    1'b0};
    tv[3]  = '{64'h8,     64'h0,     64'h0, 4'd5,  1'b0, 1'b0, 1'b1, 64'hFFFF, 1'b0};
    tv[4]  = '{64'h0,     64'h8,     64'h8, 4'd5,  1'b0, 1'b0, 1'b1, 64'hFFFF, 1'b0};
    tv[5]  = '{64'h8000,  64'h8000,  64'h0, 4'd5,  1'b0, 1'b0, 1'b0, 64'h0,    1'b0};
    tv[6]  = '{64'h10000, 64'h10000, 64'h0, 4'd5,  1'b0, 1'b0, 1'b1, 64'hFFFF, 1'b0};
    tv[7]  = '{64'h0,     64'h0,     64'h0, 4'd2,  1'b0, 1'b0, 1'b0, 64'h0,    1'b0};
    tv[8]  = '{64'h0,     64'h0,     64'h0, 4'd4,  1'b0, 1'b0, 1'b1, 64'hFFFF, 1'b0};
    tv[9]  = '{64'h0,     64'h0,     64'h0, 4'd15, 1'b0, 1'b0, 1'b1, 64'hFFFF, 1'b1};
    tv[10] = '{64'h0,     64'h0,     64'h0, 4'd5,  1'b1, 1'b0, 1'b0, '1,       1'b0};
    tv[11] = '{64'h0,     64'h0,     64'h0, 4'd5,  1'b0, 1'b1, 1'b0, 64'h0,    1'b0};
    tv[12] = '{64'h0,     64'h0,     64'h0, 4'd15, 1'b1, 1'b0, 1'b0, '1,       1'b1};

    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      pulse_rst();
      bus.inst_vld = tv[k].vld; bus.inst_wat = tv[k].wat; bus.inst_brn_wat = tv[k].brn;
      bus.counter = tv[k].cnt; bus.rcv = tv[k].rcv;
      set_tail(0, mk_map(16, tv[k].bad ? 3 : -1));
      #1;
      chk($sformatf("tv%0d.swt", k), 64'(bus.arch_swt), 64'(tv[k].swt));
      chk($sformatf("tv%0d.fls", k), bus.arch_swt_fls, tv[k].fls);
      chk($sformatf("tv%0d.ful", k), 64'(bus.isq_ful), 64'(tv[k].ful));
    end
    @(negedge clk);
    std_tails();
    bus.rcv = 1'b0; bus.inst_vld = '0; bus.inst_wat = '0; bus.inst_brn_wat = '0;

    // First commit from reset: H advances and segment 1 chains from tail[0].
    pulse_rst();
    bus.counter = 4'd5;
    #1;
    check_all("a0");
    step(); #1;
    check_all("a1");
    chk("a1.seg", 64'(bus.arch_seg), 64'd1);
    chk_map("a1.hed1", {{(NS-1)*MW{1'b0}}, bus.seg_hed_map_flat[MW +: MW]}, {{(NS-1)*MW{1'b0}}, mk_map(16, -1)});

    // Line 3 waiting blocks the commit until it clears.
    pulse_rst();
    bus.inst_vld = 64'h8; bus.inst_wat = 64'h8; bus.counter = 4'd5;
    #1; check_all("w0");
    step(); #1; check_all("w1");
    step(); #1;
    chk("w2.seg", 64'(bus.arch_seg), 64'd0);
    bus.inst_wat = '0;
    #1; check_all("w3");
    chk("w3.swt", 64'(bus.arch_swt), 64'd1);
    step(); #1;
    chk("w4.seg", 64'(bus.arch_seg), 64'd1);
    bus.inst_vld = '0;

    // Dispatch inside the head segment holds the commit off.
    pulse_rst();
    bus.counter = 4'd2;
    #1; chk("c2.swt", 64'(bus.arch_swt), 64'd0);
    bus.counter = 4'd4;
    #1; chk("c4.swt", 64'(bus.arch_swt), 64'd1);

    // Four back-to-back commits around the ring.
    @(negedge clk);
    pulse_rst();
    bus.rdy_raw = '0;
    for (int k = 0; k < 4; k++) begin
      bus.counter = 4'(((k + 2) % 4) * 4);
      if (k == 2) begin
        bus.counter = 4'd6;
        #1; chk("r2.ful6", 64'(bus.isq_ful), 64'd0);
        bus.counter = 4'd7;
        bus.rdy_raw = 64'h1 << 32;
        #1; chk("r2.ful7", 64'(bus.isq_ful), 64'd1);
        chk("r2.rdy0", 64'(bus.rdy_out[0]), 64'd1);
      end
      #1; check_all($sformatf("r%0d", k));
      step(); #1;
      chk($sformatf("r%0d.seg", k), 64'(bus.arch_seg), 64'((k + 1) % 4));
    end

    // Recovery coincident with a ready commit: flush only, state held across cycles.
    pulse_rst();
    bus.counter = 4'd5;
    #1; step();
    bus.counter = 4'd12; bus.rcv = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; check_all($sformatf("v%0d", k));
      chk($sformatf("v%0d.swt", k), 64'(bus.arch_swt), 64'd0);
      chk($sformatf("v%0d.fls", k), bus.arch_swt_fls, '1);
      chk($sformatf("v%0d.seg", k), 64'(bus.arch_seg), 64'd1);
      chk_map($sformatf("v%0d.map", k), {{(NS-1)*MW{1'b0}}, bus.seg_hed_map_flat[MW +: MW]},
              {{(NS-1)*MW{1'b0}}, mk_map(16, -1)});
      step();
    end
    bus.rcv = 1'b0;
    #1; chk("v3.swt", 64'(bus.arch_swt), 64'd1);

    // Unresolved tail blocks commit; then async reset mid-run.
    @(negedge clk);
    pulse_rst();
    set_tail(0, mk_map(16, 5));
    bus.counter = 4'd5;
    #1; chk("b0.swt", 64'(bus.arch_swt), 64'd0);
    step(); #1;
    chk("b1.seg", 64'(bus.arch_seg), 64'd0);
    set_tail(0, mk_map(16, -1));
    #1; step();
    bus.counter = 4'd12;
    #1; step(); #1;
    chk("b2.seg", 64'(bus.arch_seg), 64'd2);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("b3.seg", 64'(bus.arch_seg), 64'd0);
    chk("b3.swt", 64'(bus.arch_swt), 64'd0);
    chk_map("b3.hed0", {{(NS-1)*MW{1'b0}}, bus.seg_hed_map_flat[MW-1:0]}, {{(NS-1)*MW{1'b0}}, mk_map(0, -1)});
    check_all("b3");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bus.inst_vld     = {$urandom, $urandom};
      bus.inst_wat     = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      bus.inst_brn_wat = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      bus.counter      = 4'($urandom_range(0, 15));
      bus.rcv          = ($urandom_range(0, 7) == 0);
      for (int s = 0; s < NS; s++)
        set_tail(s, mk_map(int'($urandom_range(0, 63)),
                           ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1));
      rand_payload();
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        m_reset();
        #1; check_all($sformatf("rr%0d", n));
        rst_n = 1'b1;
      end
      #1; check_all($sformatf("rn%0d", n));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
